// File: rtl/secuenciador_ciclo_pkg.sv
// Shared definitions for the wash sequencer: phase encodings, default phase lengths, actuator decode.
package secuenciador_ciclo_pkg;

    localparam int unsigned FASE_W = 3;

    localparam int unsigned T_LLENADO_DEF       = 4;
    localparam int unsigned T_LAVADO_DEF        = 8;
    localparam int unsigned T_LAVADO_PESADO_DEF = 16;
    localparam int unsigned T_ENJUAGUE_DEF      = 6;
    localparam int unsigned T_CENTRIFUGADO_DEF  = 5;
    localparam int unsigned T_SECADO_DEF        = 10;

    typedef enum logic [FASE_W-1:0] {
        ST_IDLE         = 3'd0,
        ST_LLENADO      = 3'd1,
        ST_LAVADO       = 3'd2,
        ST_ENJUAGUE     = 3'd3,
        ST_CENTRIFUGADO = 3'd4,
        ST_SECADO       = 3'd5,
        ST_FIN          = 3'd6
    } fase_t;

    typedef struct packed {
        logic valvula;
        logic motor;
        logic rapido;
        logic calentador;
        logic bomba;
    } act_t;

    function automatic act_t decode_act(fase_t f, logic pesado);
        act_t a;
        a = '0;
        unique case (f)
            ST_LLENADO:      a.valvula = 1'b1;
            ST_LAVADO: begin
                a.motor      = 1'b1;
                a.calentador = pesado;
            end
            ST_ENJUAGUE: begin
                a.valvula = 1'b1;
                a.motor   = 1'b1;
                a.bomba   = 1'b1;
            end
            ST_CENTRIFUGADO: begin
                a.motor  = 1'b1;
                a.rapido = 1'b1;
                a.bomba  = 1'b1;
            end
            ST_SECADO: begin
                a.motor      = 1'b1;
                a.calentador = 1'b1;
            end
            default:         a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/secuenciador_ciclo_contador.sv
// Loadable CW-bit down-counter for phase timing; zero flag is registered alongside the value.
module contador_fase #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] value,
    output logic          zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            value <= load_val;
            zero  <= (load_val == '0);
        end else if (en) begin
            value <= value - 1'b1;
            zero  <= (value == CW'(1));
        end
    end

endmodule

// File: rtl/secuenciador_ciclo.sv
// Timed wash sequencer driven by the payment FSM grants.
// Optional door pause enabled with `define PAUSA_PUERTA_EN (adds PUERTA_ABIERTA port).
module secuenciador_ciclo
    import secuenciador_ciclo_pkg::*;
#(
    parameter int unsigned CW              = 8,
    parameter int unsigned T_LLENADO       = T_LLENADO_DEF,
    parameter int unsigned T_LAVADO        = T_LAVADO_DEF,
    parameter int unsigned T_LAVADO_PESADO = T_LAVADO_PESADO_DEF,
    parameter int unsigned T_ENJUAGUE      = T_ENJUAGUE_DEF,
    parameter int unsigned T_CENTRIFUGADO  = T_CENTRIFUGADO_DEF,
    parameter int unsigned T_SECADO        = T_SECADO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LAVADO,
    input  logic              LAVADO_PESADO,
    input  logic              SECADO,
`ifdef PAUSA_PUERTA_EN
    input  logic              PUERTA_ABIERTA,
`endif
    output logic              VALVULA_AGUA,
    output logic              MOTOR,
    output logic              MOTOR_RAPIDO,
    output logic              CALENTADOR,
    output logic              BOMBA,
    output logic              OCUPADO,
    output logic              FIN,
    output logic [FASE_W-1:0] FASE
);

    localparam logic [CW-1:0] C_LL  = CW'(T_LLENADO - 1);
    localparam logic [CW-1:0] C_LV  = CW'(T_LAVADO - 1);
    localparam logic [CW-1:0] C_LP  = CW'(T_LAVADO_PESADO - 1);
    localparam logic [CW-1:0] C_EN  = CW'(T_ENJUAGUE - 1);
    localparam logic [CW-1:0] C_CE  = CW'(T_CENTRIFUGADO - 1);
    localparam logic [CW-1:0] C_SEC = CW'(T_SECADO - 1);

    fase_t         state, nxt;
    logic          pesado, seca, arm;
    act_t          act_q;
    logic          ocupado_q, fin_q;
    logic          any_req, start, pausa;
    logic          load, cnt_en, cnt_zero;
    logic [CW-1:0] load_val, cnt_value;

    assign any_req = LAVADO | LAVADO_PESADO | SECADO;
    assign start   = (state == ST_IDLE) && arm && any_req;

`ifdef PAUSA_PUERTA_EN
    assign pausa = PUERTA_ABIERTA && (state != ST_IDLE) && (state != ST_FIN);
`else
    assign pausa = 1'b0;
`endif

    contador_fase #(.CW(CW)) u_contador (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (cnt_en),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    always_comb begin
        nxt      = state;
        load     = 1'b0;
        load_val = '0;
        cnt_en   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (LAVADO | LAVADO_PESADO) begin
                        nxt      = ST_LLENADO;
                        load_val = C_LL;
                    end else begin
                        nxt      = ST_SECADO;
                        load_val = C_SEC;
                    end
                end
            end
            ST_FIN: nxt = ST_IDLE;
            default: begin
                if (!pausa) begin
                    if (cnt_zero) begin
                        load = 1'b1;
                        unique case (state)
                            ST_LLENADO: begin
                                nxt      = ST_LAVADO;
                                load_val = pesado ? C_LP : C_LV;
                            end
                            ST_LAVADO: begin
                                nxt      = ST_ENJUAGUE;
                                load_val = C_EN;
                            end
                            ST_ENJUAGUE: begin
                                nxt      = ST_CENTRIFUGADO;
                                load_val = C_CE;
                            end
                            ST_CENTRIFUGADO: begin
                                nxt      = seca ? ST_SECADO : ST_FIN;
                                load_val = seca ? C_SEC : '0;
                            end
                            ST_SECADO: nxt = ST_FIN;
                            default:   nxt = ST_IDLE;
                        endcase
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pesado    <= 1'b0;
            seca      <= 1'b0;
            arm       <= 1'b1;
            act_q     <= '0;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state <= nxt;
            if (start) begin
                pesado <= LAVADO_PESADO;
                seca   <= SECADO;
                arm    <= 1'b0;
            end else if (!any_req) begin
                arm <= 1'b1;
            end
            act_q     <= decode_act(nxt, start ? LAVADO_PESADO : pesado);
            ocupado_q <= (nxt != ST_IDLE);
            fin_q     <= (nxt == ST_FIN);
        end
    end

    // Actuators are registered from the next state; the door pause gates them so they drop in the same cycle.
    assign VALVULA_AGUA = act_q.valvula    & ~pausa;
    assign MOTOR        = act_q.motor      & ~pausa;
    assign MOTOR_RAPIDO = act_q.rapido     & ~pausa;
    assign CALENTADOR   = act_q.calentador & ~pausa;
    assign BOMBA        = act_q.bomba      & ~pausa;
    assign OCUPADO      = ocupado_q;
    assign FIN          = fin_q;
    assign FASE         = state;

endmodule
